phase_det_mc: RTL

PHASE_DET_MC -- requirements
Module: phase_det_mc

---
 rtl/phase_det_pkg.sv | 13 +
 rtl/phase_det_ch.sv | 114 +++++++++++
 rtl/phase_det_mc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/phase_det_pkg.sv
// Shared FSM encodings and sizing helper for the multi-channel phase detector.
package phase_det_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_det_ch.sv
// One measured channel: edge synchronizer, stop divider, tic counter and
// the ARM/COUNT/DONE measurement FSM.
module phase_det_ch
    import phase_det_pkg::*;
#(
    parameter int TIC_BITS = 9,
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_BITS-1:0] div,
    input  logic                eclk,
    input  logic                start,
    input  logic                take,
    output logic                done,
    output logic                drop,
    output logic [TIC_BITS-1:0] result,
    output logic                ovf
);

    localparam logic [TIC_BITS-1:0] TIC_MAX = '1;

    function automatic logic [DIV_BITS-1:0] div_eff(input logic [DIV_BITS-1:0] d);
        return (d == '0) ? DIV_BITS'(1) : d;
    endfunction

    function automatic logic [TIC_BITS-1:0] sat_inc(input logic [TIC_BITS-1:0] v);
        return (v == TIC_MAX) ? TIC_MAX : v + TIC_BITS'(1);
    endfunction

    logic                meta_p0, sync_p1, edge_p2;
    logic                pulse, stop, armed;
    logic [DIV_BITS-1:0] div_q, div_cnt;
    logic [1:0]          state;
    logic [TIC_BITS-1:0] tic;

    // stage p0/p1: two-flop synchronizer, p2: edge detect register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
        end else begin
            meta_p0 <= eclk;
            sync_p1 <= meta_p0;
            edge_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~edge_p2;
    assign stop  = pulse && (div_cnt == div_q - DIV_BITS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            div_q   <= DIV_BITS'(1);
        end else if (!en) begin
            div_cnt <= '0;
            div_q   <= div_eff(div);
        end else if (pulse) begin
            if (stop) begin
                div_cnt <= '0;
                div_q   <= div_eff(div);
            end else begin
                div_cnt <= div_cnt + DIV_BITS'(1);
            end
        end
    end

    // A DONE channel whose result is being taken this cycle behaves as armed,
    // so a start arriving on the hand-off cycle is not lost.
    assign armed = (state == ARM) || ((state == DONE) && take);
    assign done  = (state == DONE);
    assign drop  = en && (state == DONE) && !take && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tic   <= '0;
        end else if (!en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= ARM;
                COUNT: begin
                    tic <= sat_inc(tic);
                    if (stop) state <= DONE;
                end
                default: begin
                    if (armed) begin
                        if (start) begin
                            tic   <= '0;
                            state <= stop ? DONE : COUNT;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (en && (state == COUNT) && stop) begin
            result <= sat_inc(tic);
            ovf    <= (tic == TIC_MAX);
        end else if (en && armed && start && stop) begin
            result <= '0;
            ovf    <= 1'b0;
        end
    end

endmodule

// File: rtl/phase_det_mc.sv
// Multi-channel phase detector: shared reference start divider, N_CH measuring
// channels and a round-robin arbiter feeding a single valid/ready result stream.
module phase_det_mc
    import phase_det_pkg::*;
#(
    parameter int TIC_BITS = 9,
    parameter int N_CH     = 2,
    parameter int DIV_BITS = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [DIV_BITS-1:0]        i_div_ref,
    input  logic [N_CH*DIV_BITS-1:0]   i_div_ch,
    input  logic                       i_eclk_ref,
    input  logic [N_CH-1:0]            i_eclk_ch,
    output logic [TIC_BITS-1:0]        o_tdata,
    output logic [chan_w(N_CH)-1:0]    o_tchan,
    output logic                       o_tovf,
    output logic                       o_tvalid,
    input  logic                       i_tready,
    output logic [N_CH-1:0]            o_drop
);

    localparam int CH_W = chan_w(N_CH);

    function automatic logic [DIV_BITS-1:0] div_eff(input logic [DIV_BITS-1:0] d);
        return (d == '0) ? DIV_BITS'(1) : d;
    endfunction

    function automatic int rr_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + 1 + off;
        return (s >= N_CH) ? s - N_CH : s;
    endfunction

    logic                ref_meta_p0, ref_sync_p1, ref_edge_p2;
    logic                ref_pulse, start;
    logic [DIV_BITS-1:0] ref_cnt, ref_div_q;

    // stage p0/p1: reference synchronizer, p2: edge register (same depth as channels)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_meta_p0 <= 1'b0;
            ref_sync_p1 <= 1'b0;
            ref_edge_p2 <= 1'b0;
        end else begin
            ref_meta_p0 <= i_eclk_ref;
            ref_sync_p1 <= ref_meta_p0;
            ref_edge_p2 <= ref_sync_p1;
        end
    end

    assign ref_pulse = ref_sync_p1 & ~ref_edge_p2;
    assign start     = ref_pulse && (ref_cnt == ref_div_q - DIV_BITS'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_cnt   <= '0;
            ref_div_q <= DIV_BITS'(1);
        end else if (!i_en) begin
            ref_cnt   <= '0;
            ref_div_q <= div_eff(i_div_ref);
        end else if (ref_pulse) begin
            if (start) begin
                ref_cnt   <= '0;
                ref_div_q <= div_eff(i_div_ref);
            end else begin
                ref_cnt <= ref_cnt + DIV_BITS'(1);
            end
        end
    end

    logic [N_CH-1:0]     done, take, req, ovf;
    logic [TIC_BITS-1:0] result [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        phase_det_ch #(
            .TIC_BITS (TIC_BITS),
            .DIV_BITS (DIV_BITS)
        ) u_ch (
            .clk    (i_clk),
            .rst    (i_rst),
            .en     (i_en),
            .div    (i_div_ch[k*DIV_BITS +: DIV_BITS]),
            .eclk   (i_eclk_ch[k]),
            .start  (start),
            .take   (take[k]),
            .done   (done[k]),
            .drop   (o_drop[k]),
            .result (result[k]),
            .ovf    (ovf[k])
        );
    end

    logic            out_free, grant_vld;
    logic [CH_W-1:0] grant_idx, ptr;

    // Results held while disabled are being discarded, so they never compete.
    assign req = done & {N_CH{i_en}};

    always_comb begin
        out_free  = !o_tvalid || i_tready;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_vld && req[rr_idx(ptr, i)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(rr_idx(ptr, i));
            end
        end
        take = '0;
        if (out_free && grant_vld) take[grant_idx] = 1'b1;
    end

    // stage: output register, loaded the cycle after a grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tchan  <= '0;
            o_tovf   <= 1'b0;
            ptr      <= CH_W'(N_CH - 1);
        end else if (out_free) begin
            o_tvalid <= grant_vld;
            if (grant_vld) begin
                o_tdata <= result[grant_idx];
                o_tchan <= grant_idx;
                o_tovf  <= ovf[grant_idx];
                ptr     <= grant_idx;
            end
        end
    end

endmodule
